// File: rtl/josh_pkg.sv
// Shared geometry constants for the wall column path and the streamer FSM state encodings.
package josh_pkg;
  localparam int COL_H   = 100;
  localparam int WORD_W  = 25;
  localparam int WORDS   = COL_H / WORD_W;
  localparam int ADDR_W  = 12;
  localparam int KW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int ENTRY_W = COL_H + ADDR_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/map_column_streamer_if.sv
// Column stream towards the datapath plus the narrow map ROM port.
interface map_column_streamer_if;
  import josh_pkg::*;

  logic              col_ready;
  logic              col_valid;
  logic [COL_H-1:0]  col_data;
  logic [ADDR_W-1:0] col_index;
  logic              map_end;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;

  modport master (
    input  col_ready, rom_data,
    output col_valid, col_data, col_index, map_end, rom_rd, rom_addr
  );

  modport slave (
    output col_ready, rom_data,
    input  col_valid, col_data, col_index, map_end, rom_rd, rom_addr
  );
endinterface

// File: rtl/col_fifo2.sv
// Two-entry FIFO holding assembled columns; push and pop may coincide while full.
module col_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [2];
  logic         rd_ptr, wr_ptr;
  logic [1:0]   count;
  logic         do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/map_column_streamer.sv
// Streams map columns from a word-wide ROM into a 2-deep column buffer for the datapath.
// Define MAP_LOOP_EN to wrap to column 0 at end of map instead of stopping.
module map_column_streamer
  import josh_pkg::*;
#(
  parameter int MAP_COLS = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  map_column_streamer_if.master bus
);
  localparam int                SR_W    = COL_H - WORD_W;
  localparam logic [KW-1:0]     K_LAST  = KW'(WORDS - 1);
  localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(WORDS);
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(MAP_COLS);

  logic [2:0]         state;
  logic [ADDR_W-1:0]  col, col_nxt;
  logic [KW-1:0]      k;
  logic [SR_W-1:0]    sr;
  logic [COL_H-1:0]   col_word;
  logic [ENTRY_W-1:0] head;
  logic               sentinel, at_end, push, pop;
  logic               fifo_full, fifo_empty, full_after;

  // The last word is taken straight off the ROM bus in WAIT, never via sr.
  assign col_word = {bus.rom_data, sr};
  assign sentinel = (col_word == '0);
  assign col_nxt  = col + ADDR_W'(1);
  assign at_end   = sentinel || (col_nxt == COLS_A);

  assign push = (state == ST_WAIT) && !sentinel && !start;
  assign pop  = !fifo_empty && bus.col_ready && !start;
  assign full_after = push ? (fifo_full || (!fifo_empty && !pop))
                           : (fifo_full && !pop);

  assign bus.col_valid = !fifo_empty;
  assign bus.col_index = head[ENTRY_W-1:COL_H];
  assign bus.col_data  = head[COL_H-1:0];
  assign bus.rom_rd    = (state == ST_FETCH);
  assign bus.rom_addr  = bus.rom_rd ? (col * WORDS_A + ADDR_W'(k)) : '0;

`ifdef MAP_LOOP_EN
  assign bus.map_end = 1'b0;
`else
  assign bus.map_end = (state == ST_DONE) && fifo_empty;
`endif

  col_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (start),
    .din    ({col, col_word}),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .dout   (head)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      col   <= '0;
      k     <= '0;
      sr    <= '0;
    end else if (start) begin
      state <= ST_FETCH;
      col   <= '0;
      k     <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          // rom_data lags the address by one cycle, so word k-1 lands while k is issued.
          if (k != '0) sr <= {bus.rom_data, sr[SR_W-1:WORD_W]};
          if (k == K_LAST) begin
            k     <= '0;
            state <= ST_WAIT;
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_WAIT: begin
          if (at_end) begin
`ifdef MAP_LOOP_EN
            col   <= '0;
            state <= full_after ? ST_HOLD : ST_FETCH;
`else
            state <= ST_DONE;
`endif
          end else begin
            col   <= col_nxt;
            state <= full_after ? ST_HOLD : ST_FETCH;
          end
        end
        ST_HOLD: if (!fifo_full || pop) state <= ST_FETCH;
        default: ;
      endcase
    end
  end
endmodule
